multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle control unit for the 16-bit CPU, replacing the single-cycle combinational decoder. It sequences every instruction through fetch, decode, execute, memory and writeback states and drives per-cycle datapath strobes. It holds the NZCV condition flags internally and resolves BEQ/BGT/BLT itself. It waits on a memory-ready handshake with a timeout, and latches a fault on illegal opcodes or memory timeouts.

## Interface
- INSTR_W, 16, instruction width (≥8); opcode = instr[INSTR_W-1 -: 4]
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready per access; 0 disables timeout
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr  in  INSTR_W  memory read data, captured as instruction in FETCH
- mem_ready  in  1  memory completes current access this cycle
- alu_flags  in  4  {N,Z,C,V} from ALU for the current operation
- pc_write, ir_write, reg_write, mem_read, mem_write  out  1  datapath strobes
- adr_src  out  1  0 = PC, 1 = ALU result register
- alu_src_a  out  2  00 Rs1, 01 PC, 10 old PC, 11 zero
- alu_src_b  out  2  00 Rs2, 01 extended immediate, 10 constant +1
- imm_src  out  2  00 zero-ext instr[7:0], 01 zero-ext instr[3:0], 10 sign-ext instr[11:0]
- alu_control  out  3  000 ADD, 001 SUB, 010 PASS_B, 011 LSL
- result_src  out  2  00 ALU register, 01 memory data, 10 ALU direct
- flags  out  4  registered {N,Z,C,V}
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky
- state  out  4  current state encoding (debug)

## Operation
- Opcodes: ADD 0000, SUB 0001, BEQ 0010, BGT 0011, BLT 0100, B 0101, MOV 0110, LDR 0111, LSL 1000, STR 1001, NEG 1010. 1011–1111 are illegal.
- The opcode is latched internally (op_q) when ir_write=1. All later decode uses op_q.
- Outputs are Moore, derived from state and op_q. Strobes not listed for a state are 0. Selects not listed are 00.
- States and encodings:
  - FETCH 0: adr_src=0, mem_read=1.
    - On mem_ready: ir_write=1, pc_write=1, alu_src_a=01, alu_src_b=10, ADD, result_src=10. Go to DECODE.
  - DECODE 1: alu_src_a=10, alu_src_b=01, imm_src=10, ADD (branch target is registered by the datapath).
    - ADD/SUB/NEG → EXEC_R; MOV/LSL → EXEC_I; LDR/STR → MEM_ADR; branches → BRANCH.
    - Illegal opcode → FAULT with fault_code=01.
  - EXEC_R 2: alu_src_b=00.
    - ADD: alu_src_a=00, ADD. SUB: alu_src_a=00, SUB. NEG: alu_src_a=11, SUB (0−Rs2).
    - flags ← alu_flags at the end of this cycle. Go to ALU_WB.
  - EXEC_I 3:
    - MOV: alu_src_b=01, imm_src=00, PASS_B.
    - LSL: alu_src_a=00, alu_src_b=01, imm_src=01, LSL.
    - Flags unchanged. Go to ALU_WB.
  - ALU_WB 4: reg_write=1, result_src=00. Go to FETCH.
  - MEM_ADR 5: alu_src_a=00, alu_src_b=01, imm_src=01, ADD. LDR → MEM_RD; STR → MEM_WR.
  - MEM_RD 6: adr_src=1, mem_read=1. On mem_ready go to MEM_WB.
  - MEM_WB 7: reg_write=1, result_src=01. Go to FETCH.
  - MEM_WR 8: adr_src=1, mem_write=1, held until mem_ready. Then go to FETCH.
  - BRANCH 9: pc_write=1 only if taken, result_src=00. Go to FETCH.
    - B: always taken. BEQ: Z. BGT: !Z && (N==V). BLT: N!=V.
  - FAULT 10: all strobes 0. Held until reset.
- Only EXEC_R writes flags.

## Timing
- Reset (rst_n=0 at a clock edge): state=FETCH, op_q=0, flags=0000, fault_code=00, timeout counter=0. Outputs take FETCH values from the next cycle.
- Reset wins over every other event, including mid-wait and FAULT.
- Latency with mem_ready held high:
  - ADD/SUB/NEG/MOV/LSL: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
- Each cycle of mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle. Strobes stay asserted during the wait.
- Timeout counter:
  - Width $clog2(MEM_TIMEOUT+1). Cleared on entry to any wait state.
  - Increments each cycle in which mem_ready=0.
  - If the counter equals MEM_TIMEOUT while mem_ready=0, go to FAULT and set fault_code=10.
  - mem_ready=1 in the same cycle takes precedence over timeout.
- MEM_TIMEOUT=0: waits are unbounded.
- The flag update in EXEC_R is visible to a branch decoded immediately after: BRANCH samples flags no earlier than 3 cycles later.

## Test plan
- Reset, then ADD (0x0123) with mem_ready=1: state sequence 0,1,2,4,0; reg_write=1 only in cycle 4; flags captured from alu_flags.
- SUB with alu_flags=0100, then BEQ: pc_write=1 in BRANCH. Repeat with flags 0000: pc_write=0 in BRANCH. BLT with N=1, V=0: taken.
- LDR with mem_ready low for 3 cycles in MEM_RD: mem_read held 4 cycles, then MEM_WB with result_src=01; total 8 cycles.
- STR with mem_ready stuck low, MEM_TIMEOUT=15: FAULT reached after 15 wait cycles; fault_code=10; all strobes 0 until rst_n=0.
- Opcode 1111: DECODE → FAULT; fault_code=01; flags unchanged.
- rst_n=0 asserted in MEM_WR: next cycle state=FETCH, mem_write=0, flags=0000, fault_code=00.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the 16-bit CPU: sequences fetch/decode/execute/memory/writeback,
// owns the NZCV flags, resolves conditional branches and latches sticky faults.
module multicycle_control #(
  parameter int INSTR_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic [3:0]         alu_flags,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic [1:0]         result_src,
  output logic [3:0]         flags,
  output logic [1:0]         fault_code,
  output logic [3:0]         state
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_FAULT   = 4'd10
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b0010;
  localparam logic [3:0] OP_BGT = 4'b0011;
  localparam logic [3:0] OP_BLT = 4'b0100;
  localparam logic [3:0] OP_B   = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_LDR = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_NEG = 4'b1010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b010;
  localparam logic [2:0] ALU_LSL  = 3'b011;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic [3:0]       flags_reg;
  logic [1:0]       fault_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             waiting;
  logic             timeout_hit;
  logic             branch_taken;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^instr[INSTR_W-5:0];

  // The current low cycle counts toward the limit, so MEM_TIMEOUT low cycles fault.
  always_comb begin
    waiting      = ((state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                    (state_reg == S_MEM_WR)) && !mem_ready;
    wait_cnt_inc = wait_cnt_reg + 1'b1;
    timeout_hit  = (MEM_TIMEOUT != 0) && waiting &&
                   (wait_cnt_inc == CNT_W'(MEM_TIMEOUT));
  end

  // flags = {N,Z,C,V}
  always_comb begin
    branch_taken = 1'b0;
    case (op_reg)
      OP_B:    branch_taken = 1'b1;
      OP_BEQ:  branch_taken = flags_reg[2];
      OP_BGT:  branch_taken = !flags_reg[2] && (flags_reg[3] == flags_reg[0]);
      OP_BLT:  branch_taken = (flags_reg[3] != flags_reg[0]);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_DECODE: begin
        case (op_reg)
          OP_ADD, OP_SUB, OP_NEG:         state_next = S_EXEC_R;
          OP_MOV, OP_LSL:                 state_next = S_EXEC_I;
          OP_LDR, OP_STR:                 state_next = S_MEM_ADR;
          OP_BEQ, OP_BGT, OP_BLT, OP_B:   state_next = S_BRANCH;
          default:                        state_next = S_FAULT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
      S_ALU_WB:           state_next = S_FETCH;
      S_MEM_ADR:          state_next = (op_reg == OP_LDR) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)        state_next = S_MEM_WB;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_MEM_WB:           state_next = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_BRANCH:           state_next = S_FETCH;
      S_FAULT:            state_next = S_FAULT;
      default:            state_next = S_FAULT;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    result_src  = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a   = (op_reg == OP_NEG) ? 2'b11 : 2'b00;
        alu_control = (op_reg == OP_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_EXEC_I: begin
        alu_src_b = 2'b01;
        if (op_reg == OP_MOV) begin
          alu_control = ALU_PASS;
        end else begin
          imm_src     = 2'b01;
          alu_control = ALU_LSL;
        end
      end
      S_ALU_WB: reg_write = 1'b1;
      S_MEM_ADR: begin
        alu_src_b = 2'b01;
        imm_src   = 2'b01;
      end
      S_MEM_RD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
      end
      S_MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: pc_write = branch_taken;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      op_reg       <= 4'd0;
      flags_reg    <= 4'd0;
      fault_reg    <= 2'b00;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (ir_write)
        op_reg <= instr[INSTR_W-1 -: 4];
      if (state_reg == S_EXEC_R)
        flags_reg <= alu_flags;
      if ((state_reg == S_DECODE) && (state_next == S_FAULT))
        fault_reg <= 2'b01;
      else if (timeout_hit)
        fault_reg <= 2'b10;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (waiting)
        wait_cnt_reg <= wait_cnt_inc;
    end
  end

  assign flags      = flags_reg;
  assign fault_code = fault_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a phase-list reference model.
module tb_multicycle_control;
  localparam int INSTR_W     = 16;
  localparam int MEM_TIMEOUT = 15;

  localparam int P_FETCH = 0, P_DEC = 1, P_XR = 2, P_XI = 3, P_AWB = 4, P_MA = 5;
  localparam int P_MRD = 6, P_MWB = 7, P_MWR = 8, P_BR = 9, P_FAULT = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic [INSTR_W-1:0] instr;
  logic mem_ready;
  logic [3:0] alu_flags;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src, fault_code;
  logic [2:0] alu_control;
  logic [3:0] flags, state;

  multicycle_control #(.INSTR_W(INSTR_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_flags(alu_flags),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .result_src(result_src), .flags(flags),
    .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: current phase plus the remaining phases of the instruction in flight.
  int         m_ph = P_FETCH;
  int         m_rest[$];
  logic [3:0] m_op = 4'd0;
  logic [3:0] m_flags = 4'd0;
  logic [1:0] m_fault = 2'd0;
  int         m_wait = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [16:0] exp_out(input int ph, input logic [3:0] op,
                                          input logic rdy, input logic [3:0] fl);
    logic pw, iw, rw, mr, mw, as;
    logic [1:0] sa, sb, is, rs;
    logic [2:0] ac;
    {pw, iw, rw, mr, mw, as} = 6'b0;
    sa = 0; sb = 0; is = 0; rs = 0; ac = 0;
    case (ph)
      P_FETCH: begin
        mr = 1;
        if (rdy) begin iw = 1; pw = 1; sa = 1; sb = 2; rs = 2; end
      end
      P_DEC: begin sa = 2; sb = 1; is = 2; end
      P_XR:  begin sa = (op == 4'd10) ? 2'd3 : 2'd0; ac = (op == 4'd0) ? 3'd0 : 3'd1; end
      P_XI:  begin sb = 1; is = (op == 4'd6) ? 2'd0 : 2'd1; ac = (op == 4'd6) ? 3'd2 : 3'd3; end
      P_AWB: rw = 1;
      P_MA:  begin sb = 1; is = 1; end
      P_MRD: begin as = 1; mr = 1; end
      P_MWB: begin rw = 1; rs = 1; end
      P_MWR: begin as = 1; mw = 1; end
      P_BR: begin
        if (op == 4'd5)      pw = 1;
        else if (op == 4'd2) pw = fl[2];
        else if (op == 4'd3) pw = !fl[2] && (fl[3] == fl[0]);
        else if (op == 4'd4) pw = (fl[3] != fl[0]);
      end
      default: ;
    endcase
    return {pw, iw, rw, mr, mw, as, sa, sb, is, ac, rs};
  endfunction

  task automatic load_seq(input logic [3:0] op);
    m_rest.delete();
    m_rest.push_back(P_DEC);
    case (op)
      4'd0, 4'd1, 4'd10: begin m_rest.push_back(P_XR); m_rest.push_back(P_AWB); end
      4'd6, 4'd8:        begin m_rest.push_back(P_XI); m_rest.push_back(P_AWB); end
      4'd7:              begin m_rest.push_back(P_MA); m_rest.push_back(P_MRD); m_rest.push_back(P_MWB); end
      4'd9:              begin m_rest.push_back(P_MA); m_rest.push_back(P_MWR); end
      4'd2, 4'd3, 4'd4, 4'd5: m_rest.push_back(P_BR);
      default:           m_rest.push_back(P_FAULT);
    endcase
  endtask

  task automatic model_update();
    int nxt;
    if (!rst_n) begin
      m_ph = P_FETCH; m_rest.delete(); m_flags = 0; m_fault = 0; m_op = 0; m_wait = 0;
    end else if (m_ph == P_FAULT) begin
      m_ph = P_FAULT;
    end else if ((m_ph == P_FETCH || m_ph == P_MRD || m_ph == P_MWR) && !mem_ready) begin
      m_wait++;
      if (MEM_TIMEOUT != 0 && m_wait == MEM_TIMEOUT) begin
        m_ph = P_FAULT; m_fault = 2'd2;
      end
    end else begin
      if (m_ph == P_FETCH) begin
        m_op = instr[INSTR_W-1 -: 4];
        load_seq(m_op);
      end
      if (m_ph == P_XR) m_flags = alu_flags;
      nxt = (m_rest.size() > 0) ? m_rest.pop_front() : P_FETCH;
      if (nxt == P_FAULT) m_fault = 2'd1;
      m_ph = nxt;
      m_wait = 0;
    end
  endtask

  // Apply inputs, then compare every output against the model on the falling edge.
  task automatic drive(input logic [15:0] i, input logic r, input logic [3:0] af, input logic rn);
    instr = i; mem_ready = r; alu_flags = af; rst_n = rn;
    @(negedge clk);
    chk("strobes", 32'({pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, alu_src_a,
                        alu_src_b, imm_src, alu_control, result_src}),
        32'(exp_out(m_ph, m_op, mem_ready, m_flags)));
    chk("state", 32'(state), 32'(m_ph));
    chk("flags", 32'(flags), 32'(m_flags));
    chk("fault_code", 32'(fault_code), 32'(m_fault));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_instr(input logic [15:0] i, input logic [3:0] af);
    int guard = 0;
    drive(i, 1'b1, af, 1'b1); step();
    while (m_ph != P_FETCH && guard < 12) begin
      drive(i, 1'b1, af, 1'b1); step(); guard++;
    end
    chk("instr_done", 32'(state), 32'd0);
  endtask

  task automatic branch_check(input logic [15:0] i, input logic exp_pw, input string nm);
    drive(i, 1'b1, 4'h0, 1'b1); step();
    drive(i, 1'b1, 4'h0, 1'b1); step();
    drive(i, 1'b1, 4'h0, 1'b1);
    chk({nm, "_state"}, 32'(state), 32'd9);
    chk({nm, "_pc_write"}, 32'(pc_write), 32'(exp_pw));
    step();
  endtask

  initial begin
    int mr_cnt;
    int wr_cnt;
    int burst;
    instr = 0; mem_ready = 1; alu_flags = 0; rst_n = 0;
    step(); step();

    // Reset state and ADD sequence 0,1,2,4,0
    drive(16'h0123, 1'b1, 4'h0, 1'b1);
    chk("rst_state", 32'(state), 0); chk("rst_flags", 32'(flags), 0);
    chk("rst_fault", 32'(fault_code), 0); chk("add_ir_write", 32'(ir_write), 1);
    step();
    drive(16'h0123, 1'b1, 4'h0, 1'b1); chk("add_decode", 32'(state), 1); step();
    drive(16'h0000, 1'b1, 4'b1010, 1'b1); chk("add_exec", 32'(state), 2);
    chk("add_exec_rw", 32'(reg_write), 0); step();
    drive(16'h0000, 1'b1, 4'h0, 1'b1); chk("add_wb", 32'(state), 4);
    chk("add_wb_rw", 32'(reg_write), 1); chk("add_flags", 32'(flags), 32'b1010); step();
    drive(16'h0000, 1'b1, 4'h0, 1'b1); chk("add_fetch", 32'(state), 0);
    chk("add_fetch_rw", 32'(reg_write), 0); step();
    run_instr(16'h6000, 4'h0);

    // Conditional branches on freshly written flags
    run_instr(16'h1000, 4'b0100); chk("sub_flags", 32'(flags), 32'b0100);
    branch_check(16'h2000, 1'b1, "beq_z1");
    run_instr(16'h1000, 4'b0000);
    branch_check(16'h2000, 1'b0, "beq_z0");
    run_instr(16'h1000, 4'b1000);
    branch_check(16'h4000, 1'b1, "blt_n1v0");

    // LDR with three not-ready cycles in MEM_RD
    mr_cnt = 0;
    drive(16'h7000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h7000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h7000, 1'b1, 4'h0, 1'b1); step();
    for (int k = 0; k < 4; k++) begin
      drive(16'h7000, (k == 3), 4'h0, 1'b1);
      if (mem_read && state == 4'd6) mr_cnt++;
      step();
    end
    drive(16'h0000, 1'b1, 4'h0, 1'b1);
    chk("ldr_wb_state", 32'(state), 7); chk("ldr_wb_result_src", 32'(result_src), 1); step();
    drive(16'h0000, 1'b0, 4'h0, 1'b1); chk("ldr_8cyc_fetch", 32'(state), 0); step();
    chk("ldr_mem_read_cycles", 32'(mr_cnt), 4);
    run_instr(16'h0000, 4'h0);

    // STR timing out in MEM_WR
    wr_cnt = 0;
    drive(16'h9000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h9000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h9000, 1'b1, 4'h0, 1'b1); step();
    for (int k = 0; k < 15; k++) begin
      drive(16'h9000, 1'b0, 4'h0, 1'b1);
      if (state == 4'd8 && mem_write) wr_cnt++;
      step();
    end
    chk("str_wait_cycles", 32'(wr_cnt), 15);
    for (int k = 0; k < 3; k++) begin
      drive(16'h9000, 1'b1, 4'hf, 1'b1);
      chk("timeout_state", 32'(state), 10); chk("timeout_code", 32'(fault_code), 2);
      chk("fault_strobes", 32'({pc_write, ir_write, reg_write, mem_read, mem_write}), 0);
      step();
    end
    drive(16'h0000, 1'b1, 4'h0, 1'b0); step();
    drive(16'h0000, 1'b1, 4'h0, 1'b1); chk("fault_cleared", 32'(fault_code), 0); step();
    run_instr(16'h0000, 4'h0);

    // Illegal opcode keeps flags
    run_instr(16'h1000, 4'b0011);
    drive(16'hF000, 1'b1, 4'h0, 1'b1); step();
    drive(16'hF000, 1'b1, 4'h0, 1'b1); chk("ill_decode", 32'(state), 1); step();
    drive(16'hF000, 1'b1, 4'hc, 1'b1); chk("ill_state", 32'(state), 10);
    chk("ill_code", 32'(fault_code), 1); chk("ill_flags", 32'(flags), 32'b0011); step();
    drive(16'h0000, 1'b1, 4'h0, 1'b0); step();

    // Reset during MEM_WR
    run_instr(16'h1000, 4'b1001);
    drive(16'h9000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h9000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h9000, 1'b1, 4'h0, 1'b1); step();
    drive(16'h9000, 1'b0, 4'h0, 1'b0);
    chk("rst_mw_state", 32'(state), 8); chk("rst_mw_write", 32'(mem_write), 1); step();
    drive(16'h0000, 1'b0, 4'h0, 1'b1);
    chk("rst_mw_after", 32'(state), 0); chk("rst_mw_write0", 32'(mem_write), 0);
    chk("rst_mw_flags", 32'(flags), 0); chk("rst_mw_fault", 32'(fault_code), 0); step();

    // Randomized traffic
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] op;
      logic r;
      logic rn;
      op = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      if (burst > 0) begin
        r = 1'b0; burst--;
      end else if ($urandom_range(0, 199) == 0) begin
        r = 1'b0; burst = 16;
      end else begin
        r = ($urandom_range(0, 3) != 0);
      end
      rn = !((m_ph == P_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0);
      drive({op, 12'($urandom)}, r, 4'($urandom), rn);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
